// File: rtl/a4988_step_driver.sv
// A4988 back end: turns accepted step requests into timing-legal STEP/DIR pulses, tracks signed position.
// All pins registered; step_ready is held low from handshake until the pulse's low phase has elapsed.
module a4988_step_driver #(
    parameter int DIR_SETUP_CYC = 6,
    parameter int STEP_HIGH_CYC = 27,
    parameter int STEP_LOW_CYC  = 27,
    parameter int WAKE_CYC      = 27000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wake_req,
    input  logic               step_valid,
    input  logic               step_dir,
    output logic               step_ready,
    input  logic               pos_clear,
    output logic signed [31:0] position,
    output logic               busy,
    output logic               motor_pul,
    output logic               motor_direction,
    output logic               motor_enable,
    output logic               A4988_sleep,
    output logic               A4988_reset
);

    localparam int MAX_AB  = (DIR_SETUP_CYC > STEP_HIGH_CYC) ? DIR_SETUP_CYC : STEP_HIGH_CYC;
    localparam int MAX_CD  = (STEP_LOW_CYC > WAKE_CYC) ? STEP_LOW_CYC : WAKE_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        SLEEP,
        WAKE,
        IDLE,
        DIR_SETUP,
        STEP_HI,
        STEP_LO
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          timer_done;

    assign timer_done = (timer == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SLEEP;
            timer           <= '0;
            step_ready      <= 1'b0;
            position        <= '0;
            busy            <= 1'b0;
            motor_pul       <= 1'b0;
            motor_direction <= 1'b0;
            motor_enable    <= 1'b1;
            A4988_sleep     <= 1'b0;
            A4988_reset     <= 1'b0;
        end else begin
            A4988_reset <= 1'b1;
            // Free-running decrement; each timed state reloads on entry below.
            if (!timer_done)
                timer <= timer - TW'(1);

            case (state)
                SLEEP: begin
                    if (wake_req) begin
                        state        <= WAKE;
                        A4988_sleep  <= 1'b1;
                        motor_enable <= 1'b0;
                        busy         <= 1'b1;
                        timer        <= TW'(WAKE_CYC - 1);
                    end
                end
                WAKE: begin
                    if (!wake_req) begin
                        state        <= SLEEP;
                        A4988_sleep  <= 1'b0;
                        motor_enable <= 1'b1;
                        busy         <= 1'b0;
                    end else if (timer_done) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        step_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (!wake_req) begin
                        state        <= SLEEP;
                        step_ready   <= 1'b0;
                        A4988_sleep  <= 1'b0;
                        motor_enable <= 1'b1;
                    end else if (step_valid && step_ready) begin
                        step_ready <= 1'b0;
                        busy       <= 1'b1;
                        if (step_dir == motor_direction) begin
                            state     <= STEP_HI;
                            motor_pul <= 1'b1;
                            timer     <= TW'(STEP_HIGH_CYC - 1);
                        end else begin
                            // motor_direction doubles as the latched direction of this step
                            state           <= DIR_SETUP;
                            motor_direction <= step_dir;
                            timer           <= TW'(DIR_SETUP_CYC - 1);
                        end
                    end else begin
                        step_ready <= 1'b1;
                    end
                end
                DIR_SETUP: begin
                    if (timer_done) begin
                        state     <= STEP_HI;
                        motor_pul <= 1'b1;
                        timer     <= TW'(STEP_HIGH_CYC - 1);
                    end
                end
                STEP_HI: begin
                    if (timer_done) begin
                        state     <= STEP_LO;
                        motor_pul <= 1'b0;
                        timer     <= TW'(STEP_LOW_CYC - 1);
                        position  <= motor_direction ? position + 32'sd1 : position - 32'sd1;
                    end
                end
                STEP_LO: begin
                    if (timer_done) begin
                        busy <= 1'b0;
                        if (wake_req) begin
                            state      <= IDLE;
                            step_ready <= 1'b1;
                        end else begin
                            state        <= SLEEP;
                            A4988_sleep  <= 1'b0;
                            motor_enable <= 1'b1;
                        end
                    end
                end
                default: state <= SLEEP;
            endcase

            if (pos_clear)
                position <= '0;
        end
    end

endmodule

// File: tb/tb_a4988_step_driver.sv
// Directed bench for a4988_step_driver with default 27 MHz timing parameters.
module tb_a4988_step_driver;

    localparam int DS = 6;
    localparam int HI = 27;
    localparam int LO = 27;
    localparam int WK = 27000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wake_req;
    logic        step_valid;
    logic        step_dir;
    logic        pos_clear;
    logic        step_ready;
    logic [31:0] position;
    logic        busy;
    logic        motor_pul;
    logic        motor_direction;
    logic        motor_enable;
    logic        A4988_sleep;
    logic        A4988_reset;

    int n_cmp = 0;
    int n_err = 0;
    int n;
    int h;
    int pulses;

    a4988_step_driver #(
        .DIR_SETUP_CYC(DS),
        .STEP_HIGH_CYC(HI),
        .STEP_LOW_CYC (LO),
        .WAKE_CYC     (WK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wake_req       (wake_req),
        .step_valid     (step_valid),
        .step_dir       (step_dir),
        .step_ready     (step_ready),
        .pos_clear      (pos_clear),
        .position       (position),
        .busy           (busy),
        .motor_pul      (motor_pul),
        .motor_direction(motor_direction),
        .motor_enable   (motor_enable),
        .A4988_sleep    (A4988_sleep),
        .A4988_reset    (A4988_reset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_while_pul(input logic lvl, input int bound, output int cnt);
        cnt = 0;
        while (motor_pul === lvl && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic count_until_ready(input int bound, output int cnt);
        cnt = 0;
        while (step_ready !== 1'b1 && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; wake_req = 1'b0; step_valid = 1'b0; step_dir = 1'b0; pos_clear = 1'b0;
        #2;
        check("rst_pul", motor_pul, 0);
        check("rst_dir", motor_direction, 0);
        check("rst_enable", motor_enable, 1);
        check("rst_sleep", A4988_sleep, 0);
        check("rst_reset", A4988_reset, 0);
        check("rst_pos", position, 0);
        check("rst_ready", step_ready, 0);
        check("rst_busy", busy, 0);
        repeat (3) tick();
        rst = 1'b0;
        check("reset_pin_before", A4988_reset, 0);
        tick();
        check("reset_pin_after", A4988_reset, 1);
        check("sleep_idle_ready", step_ready, 0);

        // wake sequence
        repeat (5) tick();
        wake_req = 1'b1;
        tick();
        check("wake_sleep_pin", A4988_sleep, 1);
        check("wake_enable_pin", motor_enable, 0);
        check("wake_busy", busy, 1);
        repeat (WK - 1) tick();
        check("wake_ready_early", step_ready, 0);
        tick();
        check("wake_ready", step_ready, 1);
        check("wake_busy_done", busy, 0);

        // three back-to-back +1 steps; first one needs a direction change
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        check("fwd_dir", motor_direction, 1);
        check("fwd_ready_drop", step_ready, 0);
        count_while_pul(1'b0, 40, n);
        check("fwd_dir_setup", n, DS);
        for (int k = 1; k <= 3; k++) begin
            count_while_pul(1'b1, 40, h);
            check("fwd_high", h, HI);
            check("fwd_pos", position, k);
            if (k < 3) begin
                count_while_pul(1'b0, 40, n);
                check("fwd_period", h + n, HI + LO + 1);
            end
        end
        step_valid = 1'b0;
        count_until_ready(40, n);
        check("fwd_ready_back", n, LO);

        // same-direction step: 1-cycle latency, dir latched at handshake
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        check("same_pul_latency", motor_pul, 1);
        step_valid = 1'b0; step_dir = 1'b0;
        count_while_pul(1'b1, 40, h);
        check("same_high", h, HI);
        check("same_pos", position, 4);
        check("same_dir_latched", motor_direction, 1);
        count_until_ready(40, n);
        check("same_ready_back", n, LO);

        // reversal
        step_valid = 1'b1; step_dir = 1'b0;
        tick();
        check("rev_dir", motor_direction, 0);
        check("rev_pul_low", motor_pul, 0);
        step_valid = 1'b0;
        count_while_pul(1'b0, 40, n);
        check("rev_setup", n, DS);
        count_while_pul(1'b1, 40, h);
        check("rev_high", h, HI);
        check("rev_pos", position, 3);
        count_until_ready(40, n);

        // wrap
        force dut.position = 32'h7FFF_FFFF;
        tick();
        release dut.position;
        tick();
        check("preload_pos", position, 32'h7FFF_FFFF);
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        count_while_pul(1'b0, 40, n);
        count_while_pul(1'b1, 40, h);
        check("wrap_pos", position, 32'h8000_0000);
        count_until_ready(40, n);

        // pos_clear beats the -1 update in the same cycle
        step_valid = 1'b1; step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        count_while_pul(1'b0, 40, n);
        repeat (HI - 1) tick();
        check("clr_last_high", motor_pul, 1);
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        check("clr_pul_fall", motor_pul, 0);
        check("clr_pos", position, 0);
        count_until_ready(40, n);
        check("clr_ready_back", n, LO);

        // sleep request during STEP_HI
        step_valid = 1'b1; step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        check("slp_pul", motor_pul, 1);
        wake_req = 1'b0;
        count_while_pul(1'b1, 40, h);
        check("slp_full_high", h, HI);
        check("slp_pos", position, 32'hFFFF_FFFF);
        repeat (LO - 1) tick();
        check("slp_still_awake", A4988_sleep, 1);
        check("slp_still_busy", busy, 1);
        tick();
        check("slp_sleep_pin", A4988_sleep, 0);
        check("slp_enable_pin", motor_enable, 1);
        check("slp_busy", busy, 0);
        step_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (motor_pul === 1'b1 || step_ready !== 1'b0) pulses++;
        end
        check("slp_no_ready", pulses, 0);
        step_valid = 1'b0;

        // re-wake
        wake_req = 1'b1;
        tick();
        count_until_ready(WK + 100, n);
        check("rewake_delay", n, WK);

        // async reset in DIR_SETUP
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        check("ar_dir_set", motor_direction, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("ar_dir", motor_direction, 0);
        check("ar_pul", motor_pul, 0);
        check("ar_sleep", A4988_sleep, 0);
        check("ar_busy", busy, 0);
        check("ar_reset_pin", A4988_reset, 0);
        wake_req = 1'b0;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (motor_pul === 1'b1) pulses++;
        end
        check("ar_no_pulse", pulses, 0);
        check("ar_reset_pin_up", A4988_reset, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
